// File: rtl/rx_frame_sampler_if.sv
//------------------------------------------------------------------------------
// Module      : rx_frame_sampler_if
// Description : Serial line and received-frame status bundle for rx_frame_sampler.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface rx_frame_sampler_if;
    logic       rx_in;
    logic       detected;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_error;
    logic       parity_error;
    logic       busy;

    modport master (
        output rx_in,
        output detected,
        input  data_out,
        input  data_valid,
        input  frame_error,
        input  parity_error,
        input  busy
    );

    modport slave (
        input  rx_in,
        input  detected,
        output data_out,
        output data_valid,
        output frame_error,
        output parity_error,
        output busy
    );
endinterface

`default_nettype wire

// File: rtl/rx_frame_sampler.sv
//------------------------------------------------------------------------------
// Module      : rx_frame_sampler
// Description : UART frame sampler; samples data/parity/stop bits at bit-period
//               boundaries after a qualified start. Optional macro: RX_PARITY_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rx_frame_sampler #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic               baud_clk,
    input  logic               rst,
    rx_frame_sampler_if.slave  bus
);

    localparam int                TICK_W   = $clog2(OVERSAMPLE);
    localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(OVERSAMPLE - 1);
    localparam logic [2:0]        LAST_BIT = 3'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
`ifdef RX_PARITY_EN
        PARITY = 2'd2,
`endif
        STOP   = 2'd3
    } state_t;

    state_t            state;
    logic              detected_q;
    logic [TICK_W-1:0] tick;
    logic [2:0]        bit_idx;
    logic [7:0]        shift;
    logic [7:0]        data_reg;
    logic              valid_reg;
    logic              ferr_reg;
    logic              busy_reg;
`ifdef RX_PARITY_EN
    logic              par_bit;
    logic              perr_reg;
`endif

    always_ff @(posedge baud_clk) begin
        if (rst) begin
            state      <= IDLE;
            detected_q <= 1'b0;
            tick       <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            data_reg   <= '0;
            valid_reg  <= 1'b0;
            ferr_reg   <= 1'b0;
            busy_reg   <= 1'b0;
`ifdef RX_PARITY_EN
            par_bit    <= 1'b0;
            perr_reg   <= 1'b0;
`endif
        end else begin
            detected_q <= bus.detected;
            valid_reg  <= 1'b0;
            ferr_reg   <= 1'b0;
`ifdef RX_PARITY_EN
            perr_reg   <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    // Only a fresh rising edge starts a frame; a held-high
                    // qualifier (line break) cannot retrigger.
                    if (bus.detected && !detected_q) begin
                        state    <= DATA;
                        tick     <= '0;
                        bit_idx  <= '0;
                        busy_reg <= 1'b1;
                    end
                end
                default: begin
                    if (tick == TICK_MAX) begin
                        tick <= '0;
                        case (state)
                            DATA: begin
                                shift[bit_idx] <= bus.rx_in;
                                if (bit_idx == LAST_BIT) begin
`ifdef RX_PARITY_EN
                                    state <= PARITY;
`else
                                    state <= STOP;
`endif
                                end else begin
                                    bit_idx <= bit_idx + 3'd1;
                                end
                            end
`ifdef RX_PARITY_EN
                            PARITY: begin
                                par_bit <= bus.rx_in;
                                state   <= STOP;
                            end
`endif
                            STOP: begin
                                state    <= IDLE;
                                busy_reg <= 1'b0;
                                if (bus.rx_in) begin
                                    data_reg  <= shift;
                                    valid_reg <= 1'b1;
`ifdef RX_PARITY_EN
                                    // Unused upper shift bits stay zero, so even parity
                                    // over the whole register is exact.
                                    perr_reg  <= ^{shift, par_bit};
`endif
                                end else begin
                                    ferr_reg <= 1'b1;
                                end
                            end
                            default: begin
                                state    <= IDLE;
                                busy_reg <= 1'b0;
                            end
                        endcase
                    end else begin
                        tick <= tick + TICK_W'(1);
                    end
                end
            endcase
        end
    end

    assign bus.data_out    = data_reg;
    assign bus.data_valid  = valid_reg;
    assign bus.frame_error = ferr_reg;
    assign bus.busy        = busy_reg;
`ifdef RX_PARITY_EN
    assign bus.parity_error = perr_reg;
`else
    assign bus.parity_error = 1'b0;
`endif

endmodule

`default_nettype wire
